// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared definitions for the MIPS fetch path: fetch FSM state
//           encodings, next-PC select codes, instruction size and the
//           word-alignment mask applied to redirect targets.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Fetch control FSM states
   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_DRAIN = 2'd2,
      FETCH_HALT  = 2'd3
   } fetch_state_e;

   // Next-PC source selected by the fetch FSM
   typedef enum logic [1:0] {
      PC_SEL_HOLD   = 2'd0,
      PC_SEL_SEQ    = 2'd1,
      PC_SEL_BRANCH = 2'd2,
      PC_SEL_JUMP   = 2'd3
   } pc_sel_e;

   localparam int INST_BYTES = 4;

   // Wide enough for any PC width up to 64 bits; users slice the low bits.
   localparam logic [63:0] PC_ALIGN_MASK = ~64'd3;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_mux
// Purpose : Combinational next-PC select. Redirect targets are forced to a
//           word boundary; the sequential path adds INST_BYTES and wraps
//           modulo 2^NBITS.
// Ports   : i_pc            current PC
//           i_branch_target branch destination (unaligned allowed)
//           i_jump_target   jump destination (unaligned allowed)
//           i_sel           next-PC source
//           o_pc_next       selected next PC
//           o_pc_plus4      i_pc + INST_BYTES
// Rev     : 1.0  initial release
// ============================================================================
module pc_next_mux
   import mips_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic [NBITS-1:0] i_pc,
   input  logic [NBITS-1:0] i_branch_target,
   input  logic [NBITS-1:0] i_jump_target,
   input  pc_sel_e          i_sel,
   output logic [NBITS-1:0] o_pc_next,
   output logic [NBITS-1:0] o_pc_plus4
);

   localparam logic [NBITS-1:0] c_ALIGN_MASK = PC_ALIGN_MASK[NBITS-1:0];

   always_comb begin
      o_pc_plus4 = i_pc + NBITS'(INST_BYTES);
      case (i_sel)
         PC_SEL_SEQ:    o_pc_next = o_pc_plus4;
         PC_SEL_BRANCH: o_pc_next = i_branch_target & c_ALIGN_MASK;
         PC_SEL_JUMP:   o_pc_next = i_jump_target & c_ALIGN_MASK;
         default:       o_pc_next = i_pc;
      endcase
   end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_ctrl
// Purpose : Instruction-fetch control. Owns the PC, applies branch/jump
//           redirects (flushing IF/ID), holds on stalls, and drains the pipe
//           for HALT_DRAIN cycles before committing a HALT so that a late
//           older-branch redirect can squash a wrong-path HALT.
// Ports   : i_clk, i_rst_n      clock / async active-low reset
//           i_enable            debug run/step enable (0 freezes the block)
//           i_pcSrc, i_branch_target  resolved branch taken + target
//           i_jump, i_jump_target     jump decoded in ID + target
//           i_stall             load-use stall, holds PC
//           i_halt              HALT decoded in ID
//           o_pc, o_pc_plus4    fetch address (reg) and +4 (comb)
//           o_valid             fetched instruction valid (reg)
//           o_flush_ifid        clear IF/ID at next edge (comb)
//           o_halted            processor halted (reg)
//           o_redirect_cnt      saturating redirect count, only when
//                               PC_FETCH_REDIRECT_CNT_EN is defined
// Rev     : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl
   import mips_pkg::*;
#(
   parameter int               NBITS      = 32,
   parameter logic [NBITS-1:0] RESET_PC   = '0,
   parameter int               HALT_DRAIN = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_pcSrc,
   input  logic [NBITS-1:0] i_branch_target,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_target,
   input  logic             i_stall,
   input  logic             i_halt,
   output logic [NBITS-1:0] o_pc,
   output logic [NBITS-1:0] o_pc_plus4,
   output logic             o_valid,
   output logic             o_flush_ifid,
`ifdef PC_FETCH_REDIRECT_CNT_EN
   output logic [31:0]      o_redirect_cnt,
`endif
   output logic             o_halted
);

   // Counter is loaded with HALT_DRAIN-1 and HALT is entered on the edge
   // that sees it at zero, giving exactly HALT_DRAIN edges after i_halt.
   localparam logic [2:0] c_DRAIN_INIT = 3'(HALT_DRAIN - 1);

   fetch_state_e     state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [NBITS-1:0] pc_q, pc_d;
   pc_sel_e          w_sel;
   logic             w_flush;
   logic             w_redirect;

   pc_next_mux #(
      .NBITS (NBITS)
   ) u_next (
      .i_pc            (pc_q),
      .i_branch_target (i_branch_target),
      .i_jump_target   (i_jump_target),
      .i_sel           (w_sel),
      .o_pc_next       (pc_d),
      .o_pc_plus4      (o_pc_plus4)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      w_sel      = PC_SEL_HOLD;
      w_flush    = 1'b0;
      w_redirect = 1'b0;
      if (i_enable) begin
         case (state_q)
            FETCH_IDLE: begin
               state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
               if (i_pcSrc) begin
                  w_sel      = PC_SEL_BRANCH;
                  w_flush    = 1'b1;
                  w_redirect = 1'b1;
               end else if (i_jump) begin
                  w_sel      = PC_SEL_JUMP;
                  w_flush    = 1'b1;
                  w_redirect = 1'b1;
               end else if (i_halt) begin
                  cnt_d   = c_DRAIN_INIT;
                  state_d = FETCH_DRAIN;
               end else if (!i_stall) begin
                  w_sel = PC_SEL_SEQ;
               end
            end
            FETCH_DRAIN: begin
               // Only an older branch can still redirect; it squashes HALT.
               if (i_pcSrc) begin
                  w_sel      = PC_SEL_BRANCH;
                  w_flush    = 1'b1;
                  w_redirect = 1'b1;
                  state_d    = FETCH_RUN;
               end else if (cnt_q == 3'd0) begin
                  state_d = FETCH_HALT;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               // FETCH_HALT: sticky until reset
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= FETCH_IDLE;
         cnt_q   <= 3'd0;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
      end
   end

`ifdef PC_FETCH_REDIRECT_CNT_EN
   logic [31:0] redirect_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         redirect_cnt_q <= 32'd0;
      end else if (w_redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
         redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign o_redirect_cnt = redirect_cnt_q;
`else
   logic w_unused;
   assign w_unused = w_redirect;
`endif

   assign o_pc         = pc_q;
   assign o_valid      = (state_q == FETCH_RUN);
   assign o_halted     = (state_q == FETCH_HALT);
   assign o_flush_ifid = w_flush;

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_ctrl
// Purpose : Directed self-checking bench for pc_fetch_ctrl (RESET_PC=0x100,
//           HALT_DRAIN=2). Redirect count checks exist only when
//           PC_FETCH_REDIRECT_CNT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        pcsrc;
   logic [31:0] btgt;
   logic        jump;
   logic [31:0] jtgt;
   logic        stall;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        flush;
   logic        halted;
`ifdef PC_FETCH_REDIRECT_CNT_EN
   logic [31:0] rcnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   pc_fetch_ctrl #(
      .NBITS      (32),
      .RESET_PC   (32'h0000_0100),
      .HALT_DRAIN (2)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_enable        (enable),
      .i_pcSrc         (pcsrc),
      .i_branch_target (btgt),
      .i_jump          (jump),
      .i_jump_target   (jtgt),
      .i_stall         (stall),
      .i_halt          (halt),
      .o_pc            (pc),
      .o_pc_plus4      (pc_plus4),
      .o_valid         (valid),
      .o_flush_ifid    (flush),
`ifdef PC_FETCH_REDIRECT_CNT_EN
      .o_redirect_cnt  (rcnt),
`endif
      .o_halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Jump to an address from RUN (one edge).
   task automatic goto(input logic [31:0] addr);
      jump = 1'b1;
      jtgt = addr;
      tick();
      jump = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      pcsrc  = 1'b0;
      btgt   = '0;
      jump   = 1'b0;
      jtgt   = '0;
      stall  = 1'b0;
      halt   = 1'b0;
      tick();
      tick();
      chk("rst_pc", pc, 32'h100);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      #1;
      chk("idle_pc", pc, 32'h100);
      chk("idle_valid", {31'd0, valid}, 32'd0);
      tick();
      chk("run_pc0", pc, 32'h100);
      chk("run_valid", {31'd0, valid}, 32'd1);
      tick();
      chk("run_pc1", pc, 32'h104);
      tick();
      chk("run_pc2", pc, 32'h108);
      chk("pc_plus4", pc_plus4, 32'h10C);

      // Jump redirect with unaligned target
      jump = 1'b1;
      jtgt = 32'h22;
      #1;
      chk("jump_flush", {31'd0, flush}, 32'd1);
      tick();
      jump = 1'b0;
      chk("jump_pc", pc, 32'h20);

      // Branch redirect at 0x20, target 0x43 -> 0x40
      pcsrc = 1'b1;
      btgt  = 32'h43;
      #1;
      chk("br_flush", {31'd0, flush}, 32'd1);
      tick();
      pcsrc = 1'b0;
      chk("br_pc", pc, 32'h40);
      #1;
      chk("br_flush_clr", {31'd0, flush}, 32'd0);

      // Stall for 3 cycles at 0x30
      goto(32'h30);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_flush", {31'd0, flush}, 32'd0);
         tick();
         chk("stall_pc", pc, 32'h30);
      end
      stall = 1'b0;
      tick();
      chk("stall_release", pc, 32'h34);

      // HALT at 0x50, no redirect
      goto(32'h50);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("drain_valid", {31'd0, valid}, 32'd0);
      chk("drain_pc", pc, 32'h50);
      chk("drain_halted0", {31'd0, halted}, 32'd0);
      tick();
      chk("drain_halted1", {31'd0, halted}, 32'd0);
      tick();
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halted_valid", {31'd0, valid}, 32'd0);
      pcsrc = 1'b1;
      btgt  = 32'h200;
      #1;
      chk("halt_noflush", {31'd0, flush}, 32'd0);
      tick();
      pcsrc = 1'b0;
      chk("halt_pc_hold", pc, 32'h50);

      // Async reset out of HALT
      rst_n = 1'b0;
      #1;
      chk("areset_pc", pc, 32'h100);
      chk("areset_halted", {31'd0, halted}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rerun_pc", pc, 32'h100);

      // HALT squashed by a late branch
      goto(32'h60);
      halt = 1'b1;
      tick();
      halt  = 1'b0;
      pcsrc = 1'b1;
      btgt  = 32'h80;
      #1;
      chk("squash_flush", {31'd0, flush}, 32'd1);
      tick();
      pcsrc = 1'b0;
      chk("squash_pc", pc, 32'h80);
      chk("squash_valid", {31'd0, valid}, 32'd1);
      tick();
      chk("squash_seq", pc, 32'h84);
      tick();
      tick();
      chk("squash_nohalt", {31'd0, halted}, 32'd0);
      chk("squash_pc2", pc, 32'h8C);

      // Simultaneous branch and halt: branch wins, stays in RUN
      pcsrc = 1'b1;
      halt  = 1'b1;
      btgt  = 32'h90;
      tick();
      pcsrc = 1'b0;
      halt  = 1'b0;
      chk("brhalt_pc", pc, 32'h90);
      chk("brhalt_valid", {31'd0, valid}, 32'd1);
      tick();
      chk("brhalt_seq", pc, 32'h94);

      // Wraparound
      goto(32'hFFFF_FFFC);
      chk("wrap_plus4", pc_plus4, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);

      // Enable low freezes everything and masks flush
      enable = 1'b0;
      pcsrc  = 1'b1;
      btgt   = 32'h200;
      #1;
      chk("dis_flush", {31'd0, flush}, 32'd0);
      tick();
      chk("dis_pc", pc, 32'h0);
      chk("dis_valid", {31'd0, valid}, 32'd1);
      pcsrc = 1'b0;
      tick();
      chk("dis_pc2", pc, 32'h0);
      enable = 1'b1;
      tick();
      chk("en_pc", pc, 32'h4);

      // Fresh reset, 5 branches + 2 jumps, then reset mid-DRAIN
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      for (int k = 1; k <= 5; k++) begin
         pcsrc = 1'b1;
         btgt  = 32'(k * 32'h10);
         tick();
         chk("cnt_br_pc", pc, 32'(k * 32'h10));
      end
      pcsrc = 1'b0;
      goto(32'h400);
      goto(32'h500);
      chk("cnt_jmp_pc", pc, 32'h500);
`ifdef PC_FETCH_REDIRECT_CNT_EN
      chk("redirect_cnt", rcnt, 32'd7);
`endif
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("mid_drain_valid", {31'd0, valid}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_drain_rst_pc", pc, 32'h100);
      chk("mid_drain_rst_valid", {31'd0, valid}, 32'd0);
`ifdef PC_FETCH_REDIRECT_CNT_EN
      chk("mid_drain_rst_cnt", rcnt, 32'd0);
`endif
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_pc", pc, 32'h100);
      chk("post_rst_valid", {31'd0, valid}, 32'd1);
      tick();
      chk("post_rst_halted", {31'd0, halted}, 32'd0);
      chk("post_rst_seq", pc, 32'h104);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pc_fetch_ctrl
`default_nettype wire
